sp_stage_sched: RTL

//  Sequencer and clock-enable scheduler for the SP datapath. Counts the serial input burst and latches the
//  per-transaction mode. Steps the enabled processing stages (A/B/C, one per mode bit), then drives the output burst.

---
 rtl/sp_pkg.sv | 46 ++++
 rtl/sp_cke_gen.sv | 42 ++++
 rtl/sp_stage_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared state encoding, mode bit indices and defaults for the SP stage scheduler
// Contents: state_e (IDLE, LOAD, S_A, S_B, S_C, OUT), MODE_A/B/C bit indices,
//           N_IN/N_OUT/STG_CYC defaults, next_stage() stage-skipping helper.
package sp_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      S_A  = 3'd2,
      S_B  = 3'd3,
      S_C  = 3'd4,
      OUT  = 3'd5
   } state_e;

   localparam int MODE_A = 0;
   localparam int MODE_B = 1;
   localparam int MODE_C = 2;

   localparam int N_IN_DEF    = 9;
   localparam int N_OUT_DEF   = 3;
   localparam int STG_CYC_DEF = 2;

   // State that follows cur once it completes: the next enabled stage, else OUT.
   // Later assignments win, so the lowest enabled stage is chosen.
   function automatic state_e next_stage(input state_e cur, input logic [2:0] mode);
      state_e nxt;
      nxt = OUT;
      case (cur)
         LOAD: begin
            if (mode[MODE_C]) nxt = S_C;
            if (mode[MODE_B]) nxt = S_B;
            if (mode[MODE_A]) nxt = S_A;
         end
         S_A: begin
            if (mode[MODE_C]) nxt = S_C;
            if (mode[MODE_B]) nxt = S_B;
         end
         S_B: begin
            if (mode[MODE_C]) nxt = S_C;
         end
         default: nxt = OUT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sp_cke_gen.sv
// rtl/sp_cke_gen.sv - clock-enable decode for the SP register banks
// Ports: state   - current scheduler state
//        last    - current LOAD/stage cycle is its final one
//        nxt     - state entered after the current one completes
//        cg_on   - clock gating active for this transaction
//        ld_en   - input bank write this cycle
//        cke_ld/cke_stg/cke_out - bank clock enables
module sp_cke_gen
   import sp_pkg::*;
(
   input  logic [2:0] state,
   input  logic       last,
   input  logic [2:0] nxt,
   input  logic       cg_on,
   input  logic       ld_en,
   output logic       cke_ld,
   output logic [2:0] cke_stg,
   output logic       cke_out
);

   always_comb begin
      cke_ld  = 1'b0;
      cke_stg = 3'b000;
      cke_out = 1'b0;
      if (state != IDLE || ld_en) begin
         if (!cg_on) begin
            cke_ld  = 1'b1;
            cke_stg = 3'b111;
            cke_out = 1'b1;
         end else begin
            // Each bank is opened one cycle early so its gated clock is settled
            // before the stage that writes it.
            cke_ld          = ld_en;
            cke_stg[MODE_A] = (state == S_A) || (last && nxt == S_A);
            cke_stg[MODE_B] = (state == S_B) || (last && nxt == S_B);
            cke_stg[MODE_C] = (state == S_C) || (last && nxt == S_C);
            cke_out         = (state == OUT) || (last && nxt == OUT);
         end
      end
   end

endmodule

// File: rtl/sp_stage_sched.sv
// rtl/sp_stage_sched.sv - SP datapath sequencer and bank clock-enable scheduler
// Ports: clk, rst (sync, active-high); cg_en, in_valid, in_mode[2:0] in;
//        ld_en, ld_idx[3:0] input bank load; stg_go[2:0], stg_first stage control;
//        out_valid, out_sel[1:0] output burst; cke_ld, cke_stg[2:0], cke_out bank enables;
//        busy, err (short burst), ovf (input while not accepting).
module sp_stage_sched
   import sp_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int N_OUT   = N_OUT_DEF,
   parameter int STG_CYC = STG_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cg_en,
   input  logic       in_valid,
   input  logic [2:0] in_mode,
   output logic       ld_en,
   output logic [3:0] ld_idx,
   output logic [2:0] stg_go,
   output logic       stg_first,
   output logic       out_valid,
   output logic [1:0] out_sel,
   output logic       cke_ld,
   output logic [2:0] cke_stg,
   output logic       cke_out,
   output logic       busy,
   output logic       err,
   output logic       ovf
);

   localparam int             SCW      = (STG_CYC > 1) ? $clog2(STG_CYC) : 1;
   localparam logic [3:0]     LD_LAST  = 4'(N_IN - 1);
   localparam logic [SCW-1:0] STG_LAST = SCW'(STG_CYC - 1);
   localparam logic [1:0]     OUT_LAST = 2'(N_OUT - 1);

   generate
      if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
         $error("sp_stage_sched: N_IN must be in 1..16");
      end
      if (N_OUT < 1 || N_OUT > 4) begin : g_bad_n_out
         $error("sp_stage_sched: N_OUT must be in 1..4");
      end
      if (STG_CYC < 1) begin : g_bad_stg_cyc
         $error("sp_stage_sched: STG_CYC must be >= 1");
      end
   endgenerate

   state_e         state_q, state_d;
   logic [3:0]     ld_cnt_q, ld_cnt_d;
   logic [SCW-1:0] stg_cnt_q, stg_cnt_d;
   logic [1:0]     out_cnt_q, out_cnt_d;
   logic [2:0]     mode_q, mode_d;
   logic           cg_en_q, cg_en_d;
   logic           out_valid_q, out_valid_d;
   logic [1:0]     out_sel_q, out_sel_d;

   logic in_stage;
   logic stg_last;
   logic cke_last;
   state_e cke_nxt;
   logic cg_on;

   assign in_stage = (state_q == S_A) || (state_q == S_B) || (state_q == S_C);
   assign stg_last = (stg_cnt_q == STG_LAST);

   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      stg_cnt_d = stg_cnt_q;
      out_cnt_d = out_cnt_q;
      mode_d    = mode_q;
      cg_en_d   = cg_en_q;
      ld_en     = 1'b0;
      err       = 1'b0;
      ovf       = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               ld_en   = 1'b1;
               mode_d  = in_mode;
               cg_en_d = cg_en;
               if (N_IN == 1) begin
                  state_d = next_stage(LOAD, in_mode);
               end else begin
                  state_d  = LOAD;
                  ld_cnt_d = 4'd1;
               end
            end
         end
         LOAD: begin
            if (!in_valid) begin
               err      = 1'b1;
               state_d  = IDLE;
               ld_cnt_d = 4'd0;
            end else begin
               ld_en = 1'b1;
               if (ld_cnt_q == LD_LAST) begin
                  state_d  = next_stage(LOAD, mode_q);
                  ld_cnt_d = 4'd0;
               end else begin
                  ld_cnt_d = ld_cnt_q + 4'd1;
               end
            end
         end
         S_A, S_B, S_C: begin
            ovf = in_valid;
            if (stg_last) begin
               state_d   = next_stage(state_q, mode_q);
               stg_cnt_d = '0;
            end else begin
               stg_cnt_d = stg_cnt_q + SCW'(1);
            end
         end
         OUT: begin
            ovf = in_valid;
            if (out_cnt_q == OUT_LAST) begin
               state_d   = IDLE;
               out_cnt_d = 2'd0;
            end else begin
               out_cnt_d = out_cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == OUT);
      out_sel_d   = (state_d == OUT) ? out_cnt_d : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ld_cnt_q    <= 4'd0;
         stg_cnt_q   <= '0;
         out_cnt_q   <= 2'd0;
         mode_q      <= 3'd0;
         cg_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sel_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         stg_cnt_q   <= stg_cnt_d;
         out_cnt_q   <= out_cnt_d;
         mode_q      <= mode_d;
         cg_en_q     <= cg_en_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign ld_idx    = (state_q == LOAD) ? ld_cnt_q : 4'd0;
   assign stg_go    = {state_q == S_C, state_q == S_B, state_q == S_A};
   assign stg_first = in_stage && (stg_cnt_q == '0);
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;
   assign busy      = (state_q != IDLE);

   // The final LOAD/stage cycle is known from counters alone, so the bank
   // setup enable is speculative on a LOAD that then aborts.
   assign cke_last = ((state_q == LOAD) && (ld_cnt_q == LD_LAST)) || (in_stage && stg_last);
   assign cke_nxt  = next_stage(state_q, mode_q);
   // Live cg_en only counts on the accepting cycle; afterwards the latched copy.
   assign cg_on    = busy ? cg_en_q : cg_en;

   sp_cke_gen u_cke_gen (
      .state   (state_q),
      .last    (cke_last),
      .nxt     (cke_nxt),
      .cg_on   (cg_on),
      .ld_en   (ld_en),
      .cke_ld  (cke_ld),
      .cke_stg (cke_stg),
      .cke_out (cke_out)
   );

endmodule
